door_plant: RTL

DOOR_PLANT -- requirements
Module: door_plant

---
 rtl/door_pkg.sv | 33 +++
 rtl/step_prescaler.sv | 35 +++
 rtl/door_plant.sv | 111 +++++++++++
 3 files changed

// File: rtl/door_pkg.sv
// Shared types for the door plant: motor command encoding, door FSM states
// and the idle-state decode used on reset and on a stop command.
package door_pkg;

   typedef enum logic [1:0] {
      M_STOP = 2'b00,
      M_UP   = 2'b01,
      M_DOWN = 2'b10,
      M_BAD  = 2'b11
   } motor_cmd_e;

   typedef enum logic [2:0] {
      S_CLOSED,
      S_OPEN,
      S_STOPPED,
      S_RAISING,
      S_LOWERING,
      S_FAULT
   } door_state_e;

   // Idle state implied by a resting position: closed at 0, open at travel end.
   function automatic door_state_e restState(input logic [7:0] pos, input logic [7:0] travel);
      door_state_e result;
      if (pos == 8'd0)
         result = S_CLOSED;
      else if (pos == travel)
         result = S_OPEN;
      else
         result = S_STOPPED;
      return result;
   endfunction

endpackage

// File: rtl/step_prescaler.sv
// Divides the clock down to one position-step tick every TICK_DIV enabled
// cycles; clear restarts the count so the next tick is a full period away.
module step_prescaler #(
   parameter int unsigned TICK_DIV = 50000
) (
   input  logic Clock,
   input  logic Reset,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

   logic [15:0] cntQ, cntD;

   assign tick = enable && (cntQ == LAST);

   // Clear wins over counting so a state change always restarts the period.
   always_comb begin
      cntD = cntQ;
      if (clear)
         cntD = 16'd0;
      else if (enable)
         cntD = tick ? 16'd0 : cntQ + 16'd1;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)
         cntQ <= 16'd0;
      else
         cntQ <= cntD;
   end

endmodule

// File: rtl/door_plant.sv
// Motorised door plant model: FSM driven by motor command M, stepping position
// on prescaler ticks. Optional obstruction sensing with DOOR_PLANT_OBSTRUCT_EN.
module door_plant
   import door_pkg::*;
#(
   parameter int unsigned TICK_DIV  = 50000,
   parameter int unsigned TRAVEL    = 200,
   parameter int unsigned RESET_POS = 0
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [1:0] M,
`ifdef DOOR_PLANT_OBSTRUCT_EN
   input  logic       Obstruct,
   output logic       Blocked,
`endif
   output logic       UpperLS,
   output logic       LowerLS,
   output logic [7:0] Position,
   output logic       Moving,
   output logic       Fault
);

   localparam logic [7:0] TOP     = 8'(TRAVEL);
   localparam logic [7:0] RST_POS = 8'(RESET_POS);

   door_state_e stateQ, stateD;
   logic [7:0]  posQ, posD;
   logic        movingQ, faultQ;
   logic        tick, enable, clear;
   motor_cmd_e  cmd;

   assign cmd = motor_cmd_e'(M);

   // Next state: a step only happens when the command keeps the current
   // direction; any other command changes state and restarts the prescaler.
   always_comb begin
      stateD = stateQ;
      posD   = posQ;
      if (stateQ != S_FAULT) begin
         case (cmd)
            M_BAD: stateD = S_FAULT;
            M_UP: begin
               if (stateQ == S_RAISING) begin
                  if (tick) begin
                     posD = posQ + 8'd1;
                     if (posD == TOP)
                        stateD = S_OPEN;
                  end
               end else if (posQ < TOP) begin
                  stateD = S_RAISING;
               end
            end
            M_DOWN: begin
               if (stateQ == S_LOWERING) begin
                  if (tick) begin
                     posD = posQ - 8'd1;
                     if (posD == 8'd0)
                        stateD = S_CLOSED;
                  end
               end else if (posQ != 8'd0) begin
                  stateD = S_LOWERING;
               end
            end
            default: stateD = restState(posQ, TOP);
         endcase
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         stateQ  <= restState(RST_POS, TOP);
         posQ    <= RST_POS;
         movingQ <= 1'b0;
         faultQ  <= 1'b0;
      end else begin
         stateQ  <= stateD;
         posQ    <= posD;
         movingQ <= (stateD == S_RAISING) || (stateD == S_LOWERING);
         faultQ  <= faultQ || (stateD == S_FAULT);
      end
   end

`ifdef DOOR_PLANT_OBSTRUCT_EN
   logic blocked;
   // Holding the prescaler in clear while blocked makes release resume cleanly.
   assign blocked = (stateQ == S_LOWERING) && Obstruct;
   assign Blocked = blocked;
   assign Moving  = movingQ && !blocked;
   assign enable  = ((stateQ == S_RAISING) || (stateQ == S_LOWERING)) && !blocked;
   assign clear   = (stateD != stateQ) || blocked;
`else
   assign Moving  = movingQ;
   assign enable  = (stateQ == S_RAISING) || (stateQ == S_LOWERING);
   assign clear   = (stateD != stateQ);
`endif

   step_prescaler #(.TICK_DIV(TICK_DIV)) uPrescaler (
      .Clock  (Clock),
      .Reset  (Reset),
      .enable (enable),
      .clear  (clear),
      .tick   (tick)
   );

   assign Position = posQ;
   assign UpperLS  = (posQ == TOP);
   assign LowerLS  = (posQ == 8'd0);
   assign Fault    = faultQ;

endmodule
